tx_sched: RTL and testbench
===========================

TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 Port enable, input, 1: permits start of new frames.
REQ-006 Port cts_n, input, 1: clear-to-send, active-low; 1 blocks start of new frames.
REQ-007 Port fifo_data, input, 8: show-ahead head-of-queue byte from the byte FIFO.
REQ-008 Port empty, input, 1: FIFO empty flag.
REQ-009 Port rdreq, output, 1: FIFO pop strobe, one cycle per byte consumed.
REQ-010 Port tx, output, 1: serial line, idle high.
REQ-011 Port busy, output, 1: frame in progress.
REQ-012 Port byte_count, output, 16: count of frames started since reset.

Function
REQ-013 The state machine SHALL have four states: IDLE, START, DATA, STOP.
REQ-014 Load condition SHALL be: enable=1, empty=0 and cts_n=0.
- Evaluated only in IDLE, or in the final cycle of STOP.
REQ-015 rdreq SHALL be combinational and equal to the load condition in those two cases.
- rdreq SHALL be 0 in all other cycles.
- rdreq SHALL never be 1 while empty=1.
REQ-016 On a rising edge with rdreq=1, the block SHALL:
- latch fifo_data into the shift register;
- reload the bit timer to CLKS_PER_BIT-1;
- enter START;
- increment byte_count, wrapping 0xFFFF->0x0000.
REQ-017 tx SHALL be 1 in IDLE, 0 in START, shift[0] in DATA, and 1 in STOP; tx is registered.
REQ-018 Each bit SHALL last exactly CLKS_PER_BIT cycles.
- The bit timer counts down to 0, then the next bit begins.
REQ-019 DATA SHALL send 8 bits LSB first; a 3-bit index 0..7 selects the bit.
- DATA exits to STOP after bit 7 completes.
REQ-020 STOP SHALL last STOP_BITS*CLKS_PER_BIT cycles.
REQ-021 From STOP's final cycle:
- load condition true: go directly to START, with no idle gap;
- load condition false: go to IDLE.
REQ-022 Frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
- tx falls on the edge that pops the byte.
REQ-023 Deasserting enable or asserting cts_n mid-frame SHALL NOT abort the frame.
- These inputs only gate the next load.
REQ-024 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-025 fifo_data SHALL be sampled only on the pop edge.
- Later changes to fifo_data SHALL NOT affect the frame in flight.

Reset
REQ-026 On an edge with rst_n=0, the block SHALL set the following, regardless of current state:
- state=IDLE, tx=1, busy=0, byte_count=0;
- bit timer and bit index cleared.
REQ-027 rdreq SHALL be 0 in every cycle in which rst_n=0.
REQ-028 Reset mid-frame SHALL abandon the frame; tx SHALL be 1 on the cycle after the reset edge.
REQ-029 The first possible pop SHALL be in the first cycle with rst_n=1.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless noted)
REQ-030 Single byte: FIFO holds 0xA5, enable=1, cts_n=0.
- Expect exactly one rdreq pulse.
- Expect tx = 0, 1,0,1,0,0,1,0,1, then 1: each bit held 4 cycles, 40 cycles total.
- Expect byte_count=1; busy=0 afterwards.
REQ-031 Back-to-back: FIFO holds 0x00, 0xFF.
- The second rdreq coincides with the last STOP cycle of the first frame.
- The second start bit immediately follows the first stop bit: 80 contiguous busy cycles.
REQ-032 Flow control: cts_n=1 with FIFO non-empty.
- Expect no rdreq and tx=1.
- Drop cts_n: pop on that same cycle.
- Raise cts_n mid-frame: the frame completes and no further pop occurs.
REQ-033 Empty/enable gating:
- empty=1 with enable=1: rdreq stays 0 for 100 cycles.
- empty=0 with enable=0: rdreq stays 0.
- enable dropped during DATA: the frame completes.
REQ-034 Reset mid-frame: assert rst_n=0 for 1 cycle during DATA bit 3.
- Expect tx=1, busy=0, byte_count=0 next cycle.
- Next frame starts cleanly, with a full 4-cycle start bit.
REQ-035 Two stop bits and wrap (STOP_BITS=2):
- Frame is 44 cycles.
- Preload byte_count via 65536 frames, or force it: 0xFFFF wraps to 0x0000 on the next pop.

Source files
------------

// File: rtl/tx_sched_if.sv
// +------------------------------------------------------------------+
// | tx_sched_if : show-ahead byte FIFO read port used by tx_sched    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface tx_sched_if;
  logic [7:0] fifo_data;
  logic       empty;
  logic       rdreq;

  // master is the consumer that issues pops; slave is the FIFO itself
  modport master (input fifo_data, input empty, output rdreq);
  modport slave  (output fifo_data, output empty, input rdreq);
endinterface

`default_nettype wire

// File: rtl/tx_sched.sv
// +------------------------------------------------------------------+
// | tx_sched : FIFO-fed serial transmitter, 8 data bits LSB first     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tx_sched #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        enable,
  input  wire logic        cts_n,
  tx_sched_if.master       fifo,
  output logic             tx,
  output logic             busy,
  output logic [15:0]      byte_count
);

  localparam logic [15:0] c_BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  c_STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_tx;
  logic        r_busy;
  logic [15:0] r_count;

  logic w_load_ok;
  logic w_last_stop;
  logic w_pop;

  assign w_load_ok   = enable & ~fifo.empty & ~cts_n;
  assign w_last_stop = (r_state == STOP) && (r_timer == 16'd0) && (r_idx == c_STOP_LAST);
  // Gated by rst_n so a pop can never be issued during reset
  assign w_pop       = rst_n & w_load_ok & ((r_state == IDLE) | w_last_stop);

  assign fifo.rdreq = w_pop;
  assign tx         = r_tx;
  assign busy       = r_busy;
  assign byte_count = r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= 16'd0;
      r_idx   <= 3'd0;
      r_shift <= 8'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_count <= 16'd0;
    end else if (w_pop) begin
      r_shift <= fifo.fifo_data;
      r_timer <= c_BIT_LAST;
      r_idx   <= 3'd0;
      r_state <= START;
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
      r_count <= r_count + 16'd1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
        end
        START: begin
          if (r_timer == 16'd0) begin
            r_state <= DATA;
            r_timer <= c_BIT_LAST;
            r_idx   <= 3'd0;
            r_tx    <= r_shift[0];
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        DATA: begin
          if (r_timer == 16'd0) begin
            r_timer <= c_BIT_LAST;
            if (r_idx == 3'd7) begin
              r_state <= STOP;
              r_idx   <= 3'd0;
              r_tx    <= 1'b1;
            end else begin
              // bit 0 of the shift register always holds the bit on the line
              r_idx   <= r_idx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        STOP: begin
          if (r_timer == 16'd0) begin
            if (r_idx == c_STOP_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_timer <= c_BIT_LAST;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tx_sched.sv
// +------------------------------------------------------------------+
// | tb_tx_sched : two tx_sched instances (1 and 2 stop bits) vs model |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_tx_sched;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cts_n = 1'b1;
  logic        tx0, tx1, busy0, busy1;
  logic [15:0] cnt0, cnt1;

  tx_sched_if f0 ();
  tx_sched_if f1 ();

  tx_sched #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cts_n(cts_n),
    .fifo(f0), .tx(tx0), .busy(busy0), .byte_count(cnt0)
  );

  tx_sched #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cts_n(cts_n),
    .fifo(f1), .tx(tx1), .busy(busy1), .byte_count(cnt1)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: position inside the current frame, -1 when idle
  int          m_pos   [2];
  logic [7:0]  m_byte  [2];
  logic [15:0] m_cnt   [2];
  logic        m_pred  [2];
  int          pops    [2];
  int          run     [2];
  int          last_run[2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] qhead(input int i);
    if (qsize(i) == 0) return 8'h00;
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int flen(input int i);
    return (9 + i + 1) * CPB;
  endfunction

  function automatic logic exp_tx(input int i);
    int p;
    p = m_pos[i];
    if (p < 0) return 1'b1;
    if (p < CPB) return 1'b0;
    if (p < 9 * CPB) return m_byte[i][(p - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic push(input logic [7:0] b);
    q0.push_back(b);
    q1.push_back(b);
  endtask

  task automatic drive_fifo();
    f0.empty     = (q0.size() == 0);
    f0.fifo_data = qhead(0);
    f1.empty     = (q1.size() == 0);
    f1.fifo_data = qhead(1);
  endtask

  // One clock cycle: check rdreq before the edge, advance model, check registered outputs
  task automatic step();
    logic rd0, rd1;
    logic bz;
    drive_fifo();
    #1;
    for (int i = 0; i < 2; i++)
      m_pred[i] = rst_n && enable && !cts_n && (qsize(i) != 0) &&
                  (m_pos[i] < 0 || m_pos[i] == flen(i) - 1);
    rd0 = f0.rdreq;
    rd1 = f1.rdreq;
    check("rdreq_s1", {31'd0, rd0}, {31'd0, m_pred[0]});
    check("rdreq_s2", {31'd0, rd1}, {31'd0, m_pred[1]});
    if (rd0) pops[0]++;
    if (rd1) pops[1]++;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pos[i] = -1;
        m_cnt[i] = 16'd0;
      end else if (m_pred[i]) begin
        m_pos[i]  = 0;
        m_byte[i] = qhead(i);
        m_cnt[i]  = m_cnt[i] + 16'd1;
      end else if (m_pos[i] >= 0) begin
        m_pos[i]++;
        if (m_pos[i] == flen(i)) m_pos[i] = -1;
      end
    end
    if (rd0 && q0.size() > 0) q0.delete(0);
    if (rd1 && q1.size() > 0) q1.delete(0);
    check("tx_s1",    {31'd0, tx0},   {31'd0, exp_tx(0)});
    check("tx_s2",    {31'd0, tx1},   {31'd0, exp_tx(1)});
    check("busy_s1",  {31'd0, busy0}, {31'd0, m_pos[0] >= 0});
    check("busy_s2",  {31'd0, busy1}, {31'd0, m_pos[1] >= 0});
    check("count_s1", {16'd0, cnt0},  {16'd0, m_cnt[0]});
    check("count_s2", {16'd0, cnt1},  {16'd0, m_cnt[1]});
    for (int i = 0; i < 2; i++) begin
      bz = (i == 0) ? busy0 : busy1;
      if (bz) run[i]++;
      else begin
        if (run[i] > 0) last_run[i] = run[i];
        run[i] = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      pops[i] = 0;
      last_run[i] = 0;
    end
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 2; i++) begin
      m_pos[i] = -1; m_byte[i] = 8'h00; m_cnt[i] = 16'd0;
      m_pred[i] = 1'b0; run[i] = 0;
    end
    clear_stats();
    drive_fifo();
    @(negedge clk);

    // reset state
    steps(3);
    check("reset_tx",    {31'd0, tx0},  32'd1);
    check("reset_busy",  {31'd0, busy0}, 32'd0);
    check("reset_count", {16'd0, cnt0}, 32'd0);
    rst_n = 1'b1;

    // single byte 0xA5
    clear_stats();
    enable = 1'b1; cts_n = 1'b0;
    push(8'hA5);
    steps(60);
    check("a5_pops_s1", pops[0], 1);
    check("a5_pops_s2", pops[1], 1);
    check("a5_len_s1",  last_run[0], 40);
    check("a5_len_s2",  last_run[1], 44);
    check("a5_count",   {16'd0, cnt0}, 32'd1);

    // back-to-back 0x00, 0xFF
    clear_stats();
    push(8'h00); push(8'hFF);
    steps(100);
    check("b2b_pops",   pops[0], 2);
    check("b2b_run_s1", last_run[0], 80);
    check("b2b_run_s2", last_run[1], 88);

    // flow control via cts_n
    clear_stats();
    cts_n = 1'b1;
    push(8'h3C);
    steps(20);
    check("cts_hold_pops", pops[0], 0);
    check("cts_hold_tx",   {31'd0, tx0}, 32'd1);
    cts_n = 1'b0;
    step();
    check("cts_drop_pop", pops[0], 1);
    steps(10);
    cts_n = 1'b1;
    push(8'h5A);
    steps(60);
    check("cts_mid_pops", pops[0], 1);
    check("cts_mid_len",  last_run[0], 40);
    cts_n = 1'b0;
    steps(60);

    // empty and enable gating
    clear_stats();
    steps(100);
    check("empty_pops", pops[0], 0);
    enable = 1'b0;
    push(8'h77);
    steps(30);
    check("disable_pops", pops[0], 0);
    enable = 1'b1;
    steps(20);
    enable = 1'b0;
    steps(50);
    check("en_drop_pops", pops[0], 1);
    check("en_drop_len",  last_run[0], 40);
    enable = 1'b1;

    // reset during DATA bit 3
    clear_stats();
    push(8'h99); push(8'h66);
    guard = 0;
    while (m_pos[0] != CPB + 3 * CPB + 1 && guard < 100) begin
      step();
      guard++;
    end
    check("reach_data3", {31'd0, guard < 100}, 32'd1);
    rst_n = 1'b0;
    step();
    check("midrst_tx",    {31'd0, tx0},   32'd1);
    check("midrst_busy",  {31'd0, busy0}, 32'd0);
    check("midrst_count", {16'd0, cnt0},  32'd0);
    rst_n = 1'b1;
    clear_stats();
    step();
    check("postrst_pop", pops[0], 1);
    steps(60);
    check("postrst_len", last_run[0], 40);

    // byte_count wrap on the two-stop-bit instance
    steps(60);
    force dut2.r_count = 16'hFFFF;
    m_cnt[1] = 16'hFFFF;
    step();
    release dut2.r_count;
    check("wrap_pre", {16'd0, cnt1}, 32'h0000FFFF);
    push(8'h12);
    step();
    check("wrap_post", {16'd0, cnt1}, 32'd0);
    steps(60);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      cts_n  = ($urandom_range(0, 5) == 0);
      rst_n  = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 19) == 0 && q0.size() < 4)
        push(8'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
